// File: rtl/hci_core_source_v2_pkg.sv
// hci_core_source_v2_pkg: shared FSM state type for the HCI-Core load streamer.
package hci_core_source_v2_pkg;
  typedef enum logic [1:0] {SRC2_IDLE, SRC2_WORKING, SRC2_DRAIN} hci_source_v2_state_t;
  localparam int unsigned OFFSET_W = 2;
endpackage

// File: rtl/hci_core_source_v2_if.sv
// hci_core_source_v2_if: address stream, TCDM load port and output stream of the streamer.
interface hci_core_source_v2_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TCDM_DW = 64
) ();
  logic addr_valid, addr_ready;
  logic [31:0] addr;
  logic tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid, tcdm_r_ready;
  logic [31:0] tcdm_add;
  logic [TCDM_DW/8-1:0] tcdm_be;
  logic [TCDM_DW-1:0] tcdm_r_data;
  logic stream_valid, stream_ready;
  logic [DATA_WIDTH-1:0] stream_data;
  logic [DATA_WIDTH/8-1:0] stream_strb;
  modport master (
    input addr_valid, addr, tcdm_gnt, tcdm_r_valid, tcdm_r_data, stream_ready,
    output addr_ready, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_r_ready,
    output stream_valid, stream_data, stream_strb
  );
  modport slave (
    output addr_valid, addr, tcdm_gnt, tcdm_r_valid, tcdm_r_data, stream_ready,
    input addr_ready, tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_r_ready,
    input stream_valid, stream_data, stream_strb
  );
endinterface

// File: rtl/hci_core_source_v2_buf.sv
// hci_core_source_v2_buf: flushable FIFO, registered head (no fall-through).
module hci_core_source_v2_buf #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);
  localparam int unsigned AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  assign valid_o = cnt_q != '0;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push_i ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_i ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/hci_core_source_v2.sv
// hci_core_source_v2: credit-tracked HCI-Core load streamer turning addresses into a realigned data stream.
module hci_core_source_v2
  import hci_core_source_v2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MISALIGNED_ACCESSES = 1,
  parameter int unsigned TCDM_DW = MISALIGNED_ACCESSES != 0 ? DATA_WIDTH + 32 : DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TRANS_CNT = 16,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [TRANS_CNT-1:0] tot_len_i,
  output logic                 ready_start_o,
  output logic                 done_o,
  output logic [OW-1:0]        outstanding_o,
  hci_core_source_v2_if.master bus
);
  hci_source_v2_state_t state_q, state_d;
  logic [TRANS_CNT-1:0] len_q, len_d, req_cnt_q, req_cnt_d, discard_q, discard_d;
  logic [OW-1:0] out_q, out_d, infl_q, infl_d;
  logic gnt, pop, rsp_push, off_valid, rsp_valid;
  logic [OFFSET_W-1:0] off_head, off_eff;
  logic [TCDM_DW-1:0] rsp_head, shifted;

  assign bus.tcdm_req = enable_i && state_q == SRC2_WORKING && bus.addr_valid
                        && out_q < OW'(MAX_OUTSTANDING) && req_cnt_q < len_q;
  assign gnt = bus.tcdm_req && bus.tcdm_gnt;
  assign bus.addr_ready = gnt;
  assign bus.tcdm_add = {bus.addr[31:2], 2'b00};
  assign bus.tcdm_wen = 1'b1;
  assign bus.tcdm_be = '0;
  assign bus.tcdm_r_ready = 1'b1;
  assign rsp_push = bus.tcdm_r_valid && discard_q == '0;
  assign bus.stream_valid = enable_i && off_valid && rsp_valid;
  assign pop = bus.stream_valid && bus.stream_ready;
  assign off_eff = MISALIGNED_ACCESSES != 0 ? off_head : '0;
  assign shifted = rsp_head >> {off_eff, 3'b000};
  assign bus.stream_data = shifted[DATA_WIDTH-1:0];
  assign bus.stream_strb = '1;
  assign ready_start_o = state_q == SRC2_IDLE;
  assign done_o = enable_i && state_q == SRC2_DRAIN && out_q == '0 && discard_q == '0;
  assign outstanding_o = out_q;

  hci_core_source_v2_buf #(.WIDTH(OFFSET_W), .DEPTH(MAX_OUTSTANDING)) i_off_buf (
    .clk_i, .rst_i, .flush_i(clear_i), .push_i(gnt), .pop_i(pop),
    .data_i(bus.addr[1:0]), .data_o(off_head), .valid_o(off_valid)
  );

  hci_core_source_v2_buf #(.WIDTH(TCDM_DW), .DEPTH(MAX_OUTSTANDING)) i_rsp_buf (
    .clk_i, .rst_i, .flush_i(clear_i), .push_i(rsp_push), .pop_i(pop),
    .data_i(bus.tcdm_r_data), .data_o(rsp_head), .valid_o(rsp_valid)
  );

  always_comb begin
    state_d = state_q;
    len_d = len_q;
    req_cnt_d = gnt ? req_cnt_q + TRANS_CNT'(1) : req_cnt_q;
    out_d = out_q + OW'(gnt) - OW'(pop);
    infl_d = infl_q + OW'(gnt) - OW'(rsp_push);
    discard_d = discard_q - TRANS_CNT'(bus.tcdm_r_valid && discard_q != '0);
    if (enable_i) begin
      if (state_q == SRC2_IDLE && start_i) begin
        len_d = tot_len_i;
        req_cnt_d = '0;
        state_d = tot_len_i == '0 ? SRC2_DRAIN : SRC2_WORKING;
      end else if (state_q == SRC2_WORKING && gnt && req_cnt_d == len_q) begin
        state_d = SRC2_DRAIN;
      end else if (done_o) begin
        state_d = SRC2_IDLE;
      end
    end
    // Every response already owed (old discards plus live in-flight) must be dropped after a clear.
    if (clear_i) begin
      state_d = SRC2_IDLE;
      len_d = '0;
      req_cnt_d = '0;
      out_d = '0;
      infl_d = '0;
      discard_d = discard_q + TRANS_CNT'(infl_q) - TRANS_CNT'(bus.tcdm_r_valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SRC2_IDLE;
      len_q <= '0;
      req_cnt_q <= '0;
      discard_q <= '0;
      out_q <= '0;
      infl_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      req_cnt_q <= req_cnt_d;
      discard_q <= discard_d;
      out_q <= out_d;
      infl_q <= infl_d;
    end
  end
endmodule

// File: tb/tb_hci_core_source_v2.sv
// tb_hci_core_source_v2: scoreboard bench with a latency-1 memory model and directed runs.
module tb_hci_core_source_v2;
  localparam int DW = 32, TDW = 64, MO = 4, TC = 16, OW = $clog2(MO) + 1;
  logic clk = 0, rst = 1, clear = 0, enable = 1, start = 0;
  logic [TC-1:0] tot_len = '0;
  logic ready_start, done;
  logic [OW-1:0] outstanding;
  int n_chk = 0, n_fail = 0, gnt_cnt = 0, cyc = 0, beats = 0;
  int last_beat_cyc = 0, done_cyc = 0, sim_hits = 0, g0 = 0;
  bit hold = 0, a_hs = 0;
  logic [31:0] addr_q[$];
  logic [31:0] exp_q[$];
  logic [63:0] pend[$];

  hci_core_source_v2_if #(.DATA_WIDTH(DW), .TCDM_DW(TDW)) ifc ();
  hci_core_source_v2 #(.DATA_WIDTH(DW), .MISALIGNED_ACCESSES(1), .TCDM_DW(TDW),
    .MAX_OUTSTANDING(MO), .TRANS_CNT(TC)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .enable_i(enable), .start_i(start),
    .tot_len_i(tot_len), .ready_start_o(ready_start), .done_o(done),
    .outstanding_o(outstanding), .bus(ifc)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic logic [63:0] mem_rd(logic [31:0] wa);
    return wa == 32'h200 ? 64'h8877665544332211 : {~wa, wa ^ 32'hCAFE0000};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Address generator
  initial begin
    ifc.addr_valid = 0;
    ifc.addr = '0;
    forever begin
      @(negedge clk);
      if (a_hs && addr_q.size() > 0) void'(addr_q.pop_front());
      ifc.addr_valid = addr_q.size() > 0;
      ifc.addr = addr_q.size() > 0 ? addr_q[0] : '0;
      #1 a_hs = ifc.addr_valid && ifc.addr_ready;
    end
  end

  // Memory: in-order responses one cycle after grant unless held
  initial begin
    ifc.tcdm_r_valid = 0;
    ifc.tcdm_r_data = '0;
    forever begin
      @(negedge clk);
      if (!hold && pend.size() > 0) begin
        ifc.tcdm_r_valid = 1;
        ifc.tcdm_r_data = pend.pop_front();
      end else begin
        ifc.tcdm_r_valid = 0;
        ifc.tcdm_r_data = '0;
      end
      #1;
      if (ifc.tcdm_req && ifc.tcdm_gnt) begin
        pend.push_back(mem_rd(ifc.tcdm_add));
        gnt_cnt++;
        chk("wen", ifc.tcdm_wen, 1);
      end
    end
  end

  // Stream monitor / scoreboard
  initial forever begin
    @(negedge clk);
    #1;
    if (ifc.stream_valid && ifc.stream_ready) begin
      beats++;
      last_beat_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_beat: got %0h expected no beat", ifc.stream_data);
      end else begin
        chk("stream_data", ifc.stream_data, exp_q.pop_front());
        chk("stream_strb", ifc.stream_strb, 4'hF);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [31:0] e);
    addr_q.push_back(a);
    exp_q.push_back(e);
  endtask

  task automatic kick(input logic [TC-1:0] len);
    @(negedge clk);
    start = 1;
    tot_len = len;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    bit armed;
    #1;
    while (!done && t < 300) begin
      armed = ifc.tcdm_req && ifc.tcdm_gnt && ifc.stream_valid && ifc.stream_ready && outstanding == OW'(2);
      @(negedge clk);
      #1;
      t++;
      if (armed) begin
        chk({nm, " sim_outstanding"}, outstanding, 2);
        sim_hits++;
      end
    end
    chk({nm, " done"}, done, 1);
    done_cyc = cyc;
  endtask

  initial begin
    ifc.tcdm_gnt = 1;
    ifc.stream_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst req", ifc.tcdm_req, 0);
    chk("rst addr_ready", ifc.addr_ready, 0);
    chk("rst stream_valid", ifc.stream_valid, 0);
    chk("rst done", done, 0);
    chk("rst ready_start", ready_start, 1);
    chk("rst outstanding", outstanding, 0);
    @(negedge clk);
    rst = 0;

    // Aligned run
    load(32'h100, 32'hCAFE0100);
    load(32'h104, 32'hCAFE0104);
    load(32'h108, 32'hCAFE0108);
    load(32'h10C, 32'hCAFE010C);
    g0 = gnt_cnt;
    kick(4);
    wait_done("aligned");
    chk("aligned done_after_beat", done_cyc, last_beat_cyc + 1);
    chk("aligned outstanding", outstanding, 0);
    chk("aligned grants", gnt_cnt - g0, 4);
    chk("aligned sim_hits", sim_hits > 0, 1);
    @(negedge clk);
    #1;
    chk("aligned done_pulse", done, 0);
    chk("aligned idle", ready_start, 1);
    chk("aligned exp_empty", exp_q.size(), 0);

    // Misaligned run
    load(32'h203, 32'h77665544);
    load(32'h201, 32'h55443322);
    kick(2);
    wait_done("misaligned");
    chk("misaligned exp_empty", exp_q.size(), 0);

    // Credit stall
    for (int i = 0; i < 8; i++) load(32'h300 + 4 * i, 32'hCAFE0300 + 4 * i);
    @(negedge clk);
    ifc.stream_ready = 0;
    g0 = gnt_cnt;
    kick(8);
    repeat (12) @(negedge clk);
    #1;
    chk("stall grants", gnt_cnt - g0, 4);
    chk("stall req", ifc.tcdm_req, 0);
    chk("stall outstanding", outstanding, 4);
    @(negedge clk);
    ifc.stream_ready = 1;
    @(negedge clk);
    ifc.stream_ready = 0;
    @(negedge clk);
    #1;
    chk("stall grants+1", gnt_cnt - g0, 5);
    chk("stall outstanding+1", outstanding, 4);
    chk("stall req+1", ifc.tcdm_req, 0);
    @(negedge clk);
    ifc.stream_ready = 1;
    wait_done("stall");
    chk("stall grants_all", gnt_cnt - g0, 8);
    chk("stall outstanding_end", outstanding, 0);

    // Zero length
    g0 = gnt_cnt;
    kick(0);
    #1;
    chk("zero done", done, 1);
    chk("zero req", ifc.tcdm_req, 0);
    chk("zero busy", ready_start, 0);
    @(negedge clk);
    #1;
    chk("zero done_pulse", done, 0);
    chk("zero idle", ready_start, 1);
    chk("zero grants", gnt_cnt - g0, 0);

    // Clear mid-run: three granted loads whose responses must be dropped
    addr_q.push_back(32'h400);
    addr_q.push_back(32'h404);
    addr_q.push_back(32'h408);
    hold = 1;
    g0 = gnt_cnt;
    kick(5);
    repeat (8) @(negedge clk);
    #1;
    chk("clear grants", gnt_cnt - g0, 3);
    chk("clear outstanding_pre", outstanding, 3);
    chk("clear stream_valid_pre", ifc.stream_valid, 0);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    hold = 0;
    #1;
    chk("clear idle", ready_start, 1);
    chk("clear outstanding", outstanding, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("clear stream_valid", ifc.stream_valid, 0);
    end
    load(32'h500, 32'hCAFE0500);
    load(32'h504, 32'hCAFE0504);
    kick(2);
    wait_done("post_clear");
    chk("post_clear exp_empty", exp_q.size(), 0);
    chk("post_clear outstanding", outstanding, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal;
  end
endmodule
